// File: rtl/mat_result_collect.sv
// Pairs the tagged real/imaginary result stream, accumulates DIM products per element
// and writes each complex element to the result memory. Define MAT_SATURATE_EN to clamp outputs.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mat_result_collect #(
  parameter int DIM    = 4,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 we_in,
  input  logic                 state,
  input  logic [`WORD_LEN-1:0] result_in,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [`WORD_LEN-1:0] mem_re,
  output logic [`WORD_LEN-1:0] mem_im,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  localparam int WL = `WORD_LEN;
  localparam int AW = WL + 4;
  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);

  // Handshake: the stream has no backpressure; a word is presented when we_in=1 and
  // is consumed in that same cycle, tagged by state (0 = real, 1 = imaginary).

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [CW-1:0]        row_q, row_d, col_q, col_d, k_q, k_d;
  logic                 exp_im_q, exp_im_d;
  logic                 err_q, err_d;
  logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [WL-1:0]        mem_re_q, mem_re_d, mem_im_q, mem_im_d;

  logic signed [AW-1:0] in_ext, sum_re, sum_im;
  logic [WL-1:0]        conv_re, conv_im;
  logic [31:0]          addr_full;
  logic                 word_ok, accept_im, elem_end, mat_end;

  assign in_ext    = {{4{result_in[WL-1]}}, result_in};
  assign sum_re    = acc_re_q + in_ext;
  assign sum_im    = acc_im_q + in_ext;
  assign word_ok   = (fsm_q == S_RUN) && we_in && (state == exp_im_q);
  assign accept_im = word_ok && state;
  assign elem_end  = accept_im && (k_q == LAST_IDX);
  assign mat_end   = elem_end && (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign addr_full = 32'(row_q) * DIM + 32'(col_q);

  // The element's last imaginary word is folded in on the fly, so the output
  // registers capture the finished sums at the same edge that accepts it.
  always_comb begin
    conv_re = acc_re_q[WL-1:0];
    conv_im = sum_im[WL-1:0];
`ifdef MAT_SATURATE_EN
    if (acc_re_q[AW-1:WL-1] != {(AW-WL+1){acc_re_q[AW-1]}})
      conv_re = acc_re_q[AW-1] ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}};
    if (sum_im[AW-1:WL-1] != {(AW-WL+1){sum_im[AW-1]}})
      conv_im = sum_im[AW-1] ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (start) fsm_d = S_RUN;
      S_RUN:   if (mat_end) fsm_d = S_FLUSH;
      S_FLUSH: fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    exp_im_d   = exp_im_q;
    err_d      = err_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_re_d   = mem_re_q;
    mem_im_d   = mem_im_q;
    if (fsm_q == S_IDLE && start) begin
      row_d    = '0;
      col_d    = '0;
      k_d      = '0;
      exp_im_d = 1'b0;
      err_d    = 1'b0;
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (fsm_q == S_RUN && we_in) begin
      if (!word_ok) begin
        err_d = 1'b1;
      end else if (!state) begin
        acc_re_d = sum_re;
        exp_im_d = 1'b1;
      end else begin
        exp_im_d = 1'b0;
        if (elem_end) begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_full[ADDR_W-1:0];
          mem_re_d   = conv_re;
          mem_im_d   = conv_im;
          acc_re_d   = '0;
          acc_im_d   = '0;
          k_d        = '0;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          acc_im_d = sum_im;
          k_d      = k_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      exp_im_q   <= 1'b0;
      err_q      <= 1'b0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_re_q   <= '0;
      mem_im_q   <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      exp_im_q   <= exp_im_d;
      err_q      <= err_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_re_q   <= mem_re_d;
      mem_im_q   <= mem_im_d;
    end
  end

  always_comb begin
    busy      = (fsm_q == S_RUN);
    done      = (fsm_q == S_FLUSH);
    err       = err_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_re    = mem_re_q;
    mem_im    = mem_im_q;
    dbg_state = fsm_q;
  end

endmodule

// File: tb/tb_mat_result_collect.sv
// Directed bench for mat_result_collect (DIM=2): scoreboard of written elements plus
// direct checks of reset, busy/done/err and FSM state.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_mat_result_collect;

  logic        clk = 1'b0;
  logic        rst, start, we_in, state_i;
  logic [31:0] result_in;
  logic        mem_we, busy, done, err;
  logic [1:0]  mem_addr, dbg_state;
  logic [31:0] mem_re, mem_im;

  int checks = 0;
  int failures = 0;
  logic [67:0] exp_q[$];

  mat_result_collect #(.DIM(2), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .we_in(we_in), .state(state_i),
    .result_in(result_in), .mem_we(mem_we), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_im(mem_im), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [35:0] s36(input logic [31:0] v);
    return {{4{v[31]}}, v};
  endfunction

  function automatic logic [31:0] conv(input logic signed [35:0] a);
`ifdef MAT_SATURATE_EN
    if (a > 36'sh07FFFFFFF) return 32'h7FFFFFFF;
    if (a < -36'sh080000000) return 32'h80000000;
`endif
    return a[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic st, input logic [31:0] v);
    we_in = 1'b1;
    state_i = st;
    result_in = v;
    tick();
    we_in = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams one element (two pairs) and queues the write the bench expects for it.
  task automatic send_elem(input logic [31:0] r0, input logic [31:0] i0,
                           input logic [31:0] r1, input logic [31:0] i1,
                           input int addr, input bit last);
    logic signed [35:0] ar, ai;
    ar = s36(r0) + s36(r1);
    ai = s36(i0) + s36(i1);
    word(1'b0, r0);
    word(1'b1, i0);
    word(1'b0, r1);
    word(1'b1, i1);
    exp_q.push_back({last, ~last, 2'(addr), conv(ar), conv(ai)});
  endtask

  task automatic send_random_elems(input int first);
    for (int e = first; e < 4; e++)
      send_elem($urandom, $urandom, $urandom, $urandom, e, e == 3);
  endtask

  task automatic check_flush(input string tag);
    chk({tag, "_state_flush"}, dbg_state, 2'd2);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_low"}, busy, 1'b0);
    tick();
    chk({tag, "_state_idle"}, dbg_state, 2'd0);
    chk({tag, "_done_low"}, done, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) chk("unexpected_mem_we", mem_we, 1'b0);
      else chk("elem", {done, busy, mem_addr, mem_re, mem_im}, exp_q.pop_front());
    end
    if (done && !mem_we) chk("done_without_we", done, 1'b0);
  end

  initial begin
    rst = 1'b1; start = 1'b0; we_in = 1'b0; state_i = 1'b0; result_in = '0;
    repeat (2) tick();
    chk("rst_outputs", {mem_we, mem_addr, mem_re, mem_im, busy, done, err}, '0);
    chk("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();

    // Full matrix back-to-back; first element is the 0x30/0x3 case.
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    chk("state_run", dbg_state, 2'd1);
    send_elem(32'h10, 32'h1, 32'h20, 32'h2, 0, 0);
    chk("busy_first_we", busy, 1'b1);
    send_elem(32'hFFFFFFF0, 32'h5, 32'h3, 32'hFFFFFFFF, 1, 0);
    send_random_elems(2);
    check_flush("m1");
    chk("err_clean", err, 1'b0);

    // Wrong tag while a real word is expected.
    pulse_start();
    word(1'b1, 32'h55);
    chk("err_set", err, 1'b1);
    send_elem(32'h100, 32'h7, 32'h200, 32'h9, 0, 0);
    send_random_elems(1);
    chk("err_sticky", err, 1'b1);
    check_flush("m2");

    // Reset mid-element, then words in IDLE are ignored.
    pulse_start();
    chk("err_cleared_by_start", err, 1'b0);
    word(1'b0, 32'h10);
    word(1'b1, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outputs", {mem_we, mem_addr, mem_re, mem_im, busy, done, err}, '0);
    chk("midrst_state", dbg_state, 2'd0);
    word(1'b0, 32'h1234);
    word(1'b1, 32'h77);
    word(1'b0, 32'h99);
    word(1'b1, 32'h11);
    chk("idle_ignores_we", dbg_state, 2'd0);
    chk("idle_not_busy", busy, 1'b0);

    // start held high during RUN must not disturb the element.
    pulse_start();
    start = 1'b1;
    send_elem(32'h40, 32'h4, 32'h50, 32'h6, 0, 0);
    start = 1'b0;
    chk("start_in_run_state", dbg_state, 2'd1);
    send_random_elems(1);
    check_flush("m3");

    // Accumulator overflow past the word range in both directions.
    pulse_start();
    send_elem(32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h0, 0, 0);
    send_elem(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 1, 0);
    send_elem(32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h1, 2, 0);
    send_elem(32'h0, 32'h0, 32'h0, 32'h0, 3, 1);
    check_flush("m4");

    repeat (3) tick();
    chk("queue_empty", 68'(exp_q.size()), 68'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
